ro_freq_counter: RTL and testbench

Measures the oscillation rate of one ring-oscillator instance by counting rising edges of its output over a fixed window of system clock cycles. Sits directly downstream of the ring oscillator: it drives the oscillator's `enable`, consumes `generatedClock` as `ro_clk`, and returns an edge count per measurement to the PUF response logic. All logic runs in the `CLK` domain; `ro_clk` is treated as an asynchronous data input, never as a clock.

---
 rtl/ro_freq_counter.sv | 197 +++++++++++++++++++
 tb/tb_ro_freq_counter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_counter.sv
// ro_freq_counter: counts rising edges of a ring-oscillator output over a
// fixed window of CLK cycles and reports the count once per measurement.
// ro_clk is sampled as asynchronous data through a synchronizer; it never
// clocks any flop.
// Optional build macro RO_FREQ_COUNTER_SAT_EN: when defined, the edge counter
// saturates and the overflow output reports saturation. When undefined, the
// counter wraps and overflow is tied low.
module ro_freq_counter #(
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned COUNT_W       = 16,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic               abort,
  input  logic               ro_clk,
  output logic               ro_enable,
  output logic               busy,
  output logic               result_valid,
  output logic [COUNT_W-1:0] result_count,
  output logic               overflow
);

  // One shared down-counter serves both the settle and the window phases.
  localparam int unsigned TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0]   SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   WINDOW_LOAD = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     r_hist;
  logic                     w_edge;
  logic [TMR_W-1:0]         r_timer;
  logic [COUNT_W-1:0]       r_cnt;
  logic [COUNT_W-1:0]       w_cnt_nxt;
  logic                     w_enter_settle;
  logic                     w_enter_count;
  logic                     w_enter_done;
  logic                     r_ro_enable;
  logic                     r_busy;
  logic                     r_result_valid;
  logic [COUNT_W-1:0]       r_result_count;

  // Synchronizer plus history flop; free-running in every state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ro_clk};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; abort wins over start and over timer expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort)                w_state_nxt = ST_IDLE;
        else if (r_timer == '0)   w_state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (abort)                w_state_nxt = ST_IDLE;
        else if (r_timer == '0)   w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_enter_settle = (r_state == ST_IDLE)   && (w_state_nxt == ST_SETTLE);
  assign w_enter_count  = (r_state == ST_SETTLE) && (w_state_nxt == ST_COUNT);
  assign w_enter_done   = (r_state == ST_COUNT)  && (w_state_nxt == ST_DONE);

  // Phase timer: loaded on entry to SETTLE and COUNT, counts down to zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_timer <= '0;
    end else if (w_enter_settle) begin
      r_timer <= SETTLE_LOAD;
    end else if (w_enter_count) begin
      r_timer <= WINDOW_LOAD;
    end else if (r_timer != '0) begin
      r_timer <= r_timer - TMR_W'(1);
    end
  end

`ifdef RO_FREQ_COUNTER_SAT_EN
  logic r_sat_hit;
  logic w_sat_hit_nxt;

  // Saturating increment; remembers any increment attempted at full scale.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_sat_hit_nxt = r_sat_hit;
    if (w_edge) begin
      if (r_cnt == CNT_MAX) w_sat_hit_nxt = 1'b1;
      else                  w_cnt_nxt     = r_cnt + COUNT_W'(1);
    end
  end

  // Saturation flag tracks the current window only.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sat_hit <= 1'b0;
    end else if (w_enter_count) begin
      r_sat_hit <= 1'b0;
    end else if (r_state == ST_COUNT) begin
      r_sat_hit <= w_sat_hit_nxt;
    end
  end

  logic r_overflow;

  // Overflow result is captured alongside the count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_overflow <= 1'b0;
    end else if (w_enter_done) begin
      r_overflow <= w_sat_hit_nxt;
    end
  end

  assign overflow = r_overflow;
`else
  // Wrapping increment modulo 2^COUNT_W.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_edge) w_cnt_nxt = r_cnt + COUNT_W'(1);
  end

  assign overflow = 1'b0;
`endif

  // Edge counter: cleared on entry to COUNT, advances only while counting.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (w_enter_count) begin
      r_cnt <= '0;
    end else if (r_state == ST_COUNT) begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Registered outputs, derived from the next state so they align with it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ro_enable    <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_count <= '0;
    end else begin
      r_ro_enable    <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_COUNT);
      r_busy         <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_COUNT);
      r_result_valid <= w_enter_done;
      if (w_enter_done) r_result_count <= w_cnt_nxt;
    end
  end

  assign ro_enable    = r_ro_enable;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign result_count = r_result_count;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: a generated ro_clk whose rising edges are logged
// by cycle, and a window-counting reference model over that log.
module tb_ro_freq_counter;

  localparam int S    = 16;
  localparam int W    = 1024;
  localparam int SYNC = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ro_clk = 1'b0;
  logic        ro_enable, busy, result_valid, overflow;
  logic [15:0] result_count;
  logic        ro_enable4, busy4, result_valid4, overflow4;
  logic [3:0]  result_count4;

  int n_vec = 0;
  int n_err = 0;

  ro_freq_counter #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .COUNT_W(16), .SYNC_STAGES(SYNC)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort), .ro_clk(ro_clk),
    .ro_enable(ro_enable), .busy(busy), .result_valid(result_valid),
    .result_count(result_count), .overflow(overflow));

  ro_freq_counter #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .COUNT_W(4), .SYNC_STAGES(SYNC)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort), .ro_clk(ro_clk),
    .ro_enable(ro_enable4), .busy(busy4), .result_valid(result_valid4),
    .result_count(result_count4), .overflow(overflow4));

  always #5 CLK = ~CLK;

  // cyc equals the number of rising CLK edges seen so far
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ro_clk generator: mode 0 holds a level, mode 1 is a square wave
  int   gen_mode = 0;
  logic gen_level = 1'b0;
  int   hi_len = 2;
  int   lo_len = 2;
  int   phase_cnt = 0;
  logic prev_ro = 1'b0;
  int   rise_q[$];

  always @(negedge CLK) begin
    if (gen_mode == 0) begin
      ro_clk = gen_level;
    end else if (phase_cnt <= 1) begin
      ro_clk = ~ro_clk;
      phase_cnt = ro_clk ? hi_len : lo_len;
    end else begin
      phase_cnt = phase_cnt - 1;
    end
    if (ro_clk && !prev_ro) rise_q.push_back(cyc);
    prev_ro = ro_clk;
  end

  // Reference: the window is the W cycles following the S settle cycles after
  // the start edge k; an edge is seen SYNC cycles after ro_clk rises.
  function automatic int model_count(input int k);
    int c = 0;
    foreach (rise_q[i]) begin
      if (rise_q[i] + SYNC >= k + S && rise_q[i] + SYNC <= k + S + W - 1) c++;
    end
    return c;
  endfunction

  task automatic set_square(input int hi, input int lo);
    @(negedge CLK);
    hi_len = hi; lo_len = lo; phase_cnt = 0; gen_mode = 1;
  endtask

  // Pulse start and wait (bounded) for result_valid; latency in spec cycles.
  task automatic run_measure(output int k, output int lat, output logic [15:0] rc,
                             output logic ov, output logic [3:0] rc4, output logic ov4,
                             output bit got);
    @(negedge CLK);
    rise_q.delete();
    start = 1'b1;
    k = cyc + 1;
    @(negedge CLK);
    start = 1'b0;
    got = 1'b0; lat = -1; rc = '0; ov = 1'b0; rc4 = '0; ov4 = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (result_valid) begin
        got = 1'b1; lat = cyc - k + 1;
        rc = result_count; ov = overflow; rc4 = result_count4; ov4 = overflow4;
      end else begin
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_vec++; if (ro_enable !== 1'b0) begin n_err++; $display("FAIL reset_ro_enable got=%b exp=0", ro_enable); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_result_valid got=%b exp=0", result_valid); end
    n_vec++; if (result_count !== 16'd0) begin n_err++; $display("FAIL reset_result_count got=%0d exp=0", result_count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  // One measurement with the current generator, checked against the model.
  task automatic test_measure(input string tag, output int m);
    int k, lat, d; logic [15:0] rc; logic ov; logic [3:0] rc4; logic ov4; bit got;
    run_measure(k, lat, rc, ov, rc4, ov4, got);
    m = model_count(k);
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL %s_timeout no result_valid within bound", tag);
    end else begin
      if (lat != S + W + 1) begin n_err++; $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, S + W + 1); end
      n_vec++;
      if (int'(rc) < m - 1 || int'(rc) > m + 1) begin n_err++; $display("FAIL %s_count got=%0d exp=%0d+-1", tag, rc, m); end
      n_vec++;
      if (ov !== 1'b0) begin n_err++; $display("FAIL %s_overflow got=%b exp=0", tag, ov); end
      d = (int'(rc4) - m) & 15;
`ifdef RO_FREQ_COUNTER_SAT_EN
      n_vec++;
      if (m >= 17) begin
        if (rc4 !== 4'd15 || ov4 !== 1'b1) begin n_err++; $display("FAIL %s_sat4 got=%0d/%b exp=15/1", tag, rc4, ov4); end
      end else if (int'(rc4) < m - 1 || int'(rc4) > m + 1) begin
        n_err++; $display("FAIL %s_sat4 got=%0d exp=%0d+-1", tag, rc4, m);
      end
`else
      n_vec++;
      if (!(d == 0 || d == 1 || d == 15) || ov4 !== 1'b0) begin
        n_err++; $display("FAIL %s_wrap4 got=%0d/%b exp=%0d/0", tag, rc4, ov4, m % 16);
      end
`endif
    end
  endtask

  task automatic test_clk_div4();
    int m;
    set_square(2, 2);
    test_measure("div4", m);
    n_vec++; if (m != 256) begin n_err++; $display("FAIL div4_model got=%0d exp=256", m); end
  endtask

  task automatic test_hold_levels();
    int m;
    @(negedge CLK); gen_mode = 0; gen_level = 1'b0;
    repeat (5) @(negedge CLK);
    test_measure("hold0", m);
    @(negedge CLK); gen_level = 1'b1;
    test_measure("hold1", m);
    n_vec++; if (result_count !== 16'd0) begin n_err++; $display("FAIL hold1_exact got=%0d exp=0", result_count); end
  endtask

  task automatic test_abort();
    int m_prior, k, pulses;
    set_square(2, 2);
    test_measure("prior", m_prior);
    @(negedge CLK); start = 1'b1; k = cyc + 1;
    @(negedge CLK); start = 1'b0;
    repeat (S + 499) @(negedge CLK);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    abort = 1'b1;
    @(negedge CLK); abort = 1'b0;
    n_vec++; if (ro_enable !== 1'b0) begin n_err++; $display("FAIL abort_ro_enable got=%b exp=0", ro_enable); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
    pulses = 0;
    for (int i = 0; i < 1100; i++) begin
      if (result_valid) pulses++;
      @(negedge CLK);
    end
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL abort_valid got=%0d pulses exp=0", pulses); end
    n_vec++;
    if (int'(result_count) < m_prior - 1 || int'(result_count) > m_prior + 1) begin
      n_err++; $display("FAIL abort_hold_count got=%0d exp=%0d+-1", result_count, m_prior);
    end
  endtask

  // Extra starts during SETTLE and COUNT; enable timing checked every cycle.
  task automatic test_start_ignored();
    int k, pulses, bad, first_bad;
    logic exp_en;
    set_square(2, 2);
    @(negedge CLK); start = 1'b1; k = cyc + 1;
    @(negedge CLK); start = 1'b0;
    pulses = 0; bad = 0; first_bad = -1;
    for (int i = 0; i < S + W + 40; i++) begin
      exp_en = (cyc >= k) && (cyc < k + S + W);
      if (ro_enable !== exp_en || busy !== exp_en) begin bad++; if (first_bad < 0) first_bad = cyc - k; end
      if (result_valid) begin
        pulses++;
        if (cyc != k + S + W) begin bad++; if (first_bad < 0) first_bad = cyc - k; end
      end
      start = (cyc == k + 4) || (cyc == k + S + 100);
      @(negedge CLK);
      start = 1'b0;
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL start_ignored_pulses got=%0d exp=1", pulses); end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL enable_timing got=%0d bad cycles (first at +%0d) exp=0", bad, first_bad); end
  endtask

  task automatic test_start_abort_idle();
    int seen;
    @(negedge CLK); start = 1'b1; abort = 1'b1;
    @(negedge CLK); start = 1'b0; abort = 1'b0;
    n_vec++; if (ro_enable !== 1'b0) begin n_err++; $display("FAIL start_abort_ro_enable got=%b exp=0", ro_enable); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy || ro_enable || result_valid) seen++;
      @(negedge CLK);
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL start_abort_idle got=%0d active cycles exp=0", seen); end
  endtask

  task automatic test_random();
    int m;
    for (int r = 0; r < 3; r++) begin
      set_square(int'($urandom_range(2, 6)), int'($urandom_range(2, 6)));
      test_measure($sformatf("rand%0d", r), m);
    end
  endtask

  task automatic test_reset_mid_count();
    int m;
    set_square(2, 2);
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    repeat (S + 300) @(negedge CLK);
    @(posedge CLK); #2 RST_N = 1'b0; #1;
    n_vec++; if (ro_enable !== 1'b0) begin n_err++; $display("FAIL rst_mid_ro_enable got=%b exp=0", ro_enable); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    n_vec++; if (result_count !== 16'd0) begin n_err++; $display("FAIL rst_mid_count got=%0d exp=0", result_count); end
    n_vec++; if (result_valid !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL rst_mid_flags got=%b/%b exp=0/0", result_valid, overflow); end
    @(negedge CLK); RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    test_measure("post_rst", m);
  endtask

  initial begin
    test_reset();
    test_clk_div4();
    test_hold_levels();
    test_abort();
    test_start_ignored();
    test_start_abort_idle();
    test_random();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
